team_09_wb_master: RTL and testbench
====================================

# team_09_wb_master

Wishbone classic (B4, non-pipelined) bus master that lets the team_09 user design initiate single read/write transfers on the Nebula wishbone arbitrator port (ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O out, DAT_I/ACK_I in). It is the initiator counterpart to the existing team_09 slave bus wrapper. It accepts one request at a time over a valid/ready handshake, runs the bus cycle, and returns read data or a timeout error. It sits between the team_09 core and the top-level wrapper's master outputs.

## Interface
- TIMEOUT, 255: max cycles STB_O is held awaiting ACK_I before aborting; legal range 1..65535.
- TW, 16: timeout counter width; must satisfy 2^TW > TIMEOUT.
- clk_i  in  1  system clock (wb_clk_i at top level).
- nrst  in  1  one clock; reset is synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  32  byte address.
- req_wdat  in  32  write data.
- req_sel  in  4  byte lane selects.
- rsp_valid  out  1  one-cycle pulse: transfer finished.
- rsp_rdata  out  32  read data (0 for writes and errors).
- rsp_err  out  1  transfer aborted by timeout.
- ADR_O / DAT_O  out  32  bus address / write data.
- SEL_O  out  4  bus byte selects.
- WE_O, STB_O, CYC_O  out  1  bus write enable, strobe, cycle.
- DAT_I  in  32  bus read data.
- ACK_I  in  1  bus acknowledge.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: req_ready = 1. On req_valid, latch we/adr/wdat/sel (wdat forced to 0 on reads), clear timeout counter, go BUSY. req_* ignored outside IDLE.
- BUSY: CYC_O = STB_O = 1; ADR_O, DAT_O, SEL_O, WE_O driven from latched registers. Counter increments each BUSY cycle without ACK_I.
  - ACK_I = 1: capture DAT_I into rsp_rdata if read (0 if write), rsp_err = 0, go RESP.
  - No ACK_I and counter == TIMEOUT-1: rsp_rdata = 0, rsp_err = 1, go RESP.
  - ACK_I on the timeout cycle: ACK wins, rsp_err = 0.
- RESP: rsp_valid = 1 for exactly one cycle, bus outputs idle, go IDLE.
- Outside BUSY, all bus outputs are 0 (no stale address/data on the arbitrator).
- rsp_rdata/rsp_err hold their value until the next response is loaded.
- Reset (nrst = 0 at an edge): state IDLE, all outputs 0 except req_ready = 1 after the reset edge; in-flight transfer is dropped, no response emitted, CYC_O falls the cycle after the reset edge.

## Timing
- Request accepted at edge N (IDLE, req_valid): CYC_O/STB_O high from cycle N+1.
- ACK_I sampled high at edge M: CYC_O/STB_O low from cycle M+1; rsp_valid high in cycle M+1; req_ready high in cycle M+2.
- Zero-wait slave (ACK in first strobe cycle): 3 cycles per transfer.
- Timeout: STB_O held exactly TIMEOUT cycles, rsp_valid in the following cycle.
- All outputs decoded from registered state/data only; no combinational path from ACK_I or DAT_I to any output.

## Structure
- team_09_wb_master_pkg: state enum (IDLE, BUSY, RESP), default TIMEOUT constant, request struct (we, adr, wdat, sel).
- No sub-module; the timeout counter is inline.

## Test plan
- Write 0xDEADBEEF to 0x3000_0004, sel 0xF, slave ACKs in first strobe cycle -> ADR_O=0x30000004, DAT_O=0xDEADBEEF, WE_O=1 one cycle; rsp_valid next cycle, rsp_err=0, rsp_rdata=0.
- Read 0x3000_0010, slave ACKs after 3 wait cycles with DAT_I=0x12345678 -> STB_O high 4 cycles, WE_O=0, rsp_rdata=0x12345678.
- TIMEOUT=8, slave never ACKs -> STB_O high exactly 8 cycles then low, rsp_valid with rsp_err=1, rsp_rdata=0.
- TIMEOUT=8, ACK_I on 8th strobe cycle -> rsp_err=0, data captured.
- nrst low for one edge during BUSY -> CYC_O/STB_O low next cycle, no rsp_valid, req_ready=1; a fresh request completes normally.
- req_valid held high for 4 back-to-back writes, sel 0x1/0x2/0x4/0x8 -> each accepted only in IDLE, 3-cycle spacing, SEL_O matches per transfer, 4 rsp_valid pulses.

Source files
------------

// File: rtl/team_09_wb_master_pkg.sv
// Shared types for the team_09 wishbone master: FSM states, request record, default timeout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package team_09_wb_master_pkg;

  // Default number of strobe cycles to wait for ACK_I before aborting.
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Request captured at accept time and replayed onto the bus for the whole cycle.
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
  } req_t;

endpackage

// File: rtl/team_09_wb_master.sv
// Wishbone classic single-transfer master: one request in, one bus cycle, one response pulse out.
// Latency: 3 cycles per transfer with a zero-wait slave; TIMEOUT strobe cycles plus 2 on abort.
// Backpressure: req_ready is high only in IDLE; requests offered in other states wait, responses are not stalled.
module team_09_wb_master
  import team_09_wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TW      = 16
) (
  input  logic        clk_i,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdat,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  // Counter value seen in the last strobe cycle before the transfer is abandoned.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  req_t          req_q;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          busy;
  logic          tmo_hit;

  assign busy    = (state == BUSY);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // State register; reset drops any in-flight transfer without a response.
  always_ff @(posedge clk_i) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; an ACK in the timeout cycle takes priority over the abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = BUSY;
      BUSY:    if (ACK_I || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, timeout counting and response data/error loading.
  always_ff @(posedge clk_i) begin
    if (!nrst) begin
      req_q   <= '0;
      tmo_cnt <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q.we   <= req_we;
            req_q.adr  <= req_adr;
            req_q.wdat <= req_we ? req_wdat : 32'h0;
            req_q.sel  <= req_sel;
            tmo_cnt    <= '0;
          end
        end
        BUSY: begin
          if (ACK_I) begin
            rdata_q <= req_q.we ? 32'h0 : DAT_I;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come only from registered state/data; the bus is driven to zero outside BUSY.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign CYC_O     = busy;
  assign STB_O     = busy;
  assign WE_O      = busy & req_q.we;
  assign ADR_O     = busy ? req_q.adr  : 32'h0;
  assign DAT_O     = busy ? req_q.wdat : 32'h0;
  assign SEL_O     = busy ? req_q.sel  : 4'h0;

endmodule

// File: tb/tb_team_09_wb_master.sv
// Directed bench for team_09_wb_master with TIMEOUT = 8.
// Latency: inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Backpressure: the bench acts as the wishbone slave by driving ACK_I/DAT_I per cycle.
module tb_team_09_wb_master;

  logic        clk_i = 1'b0;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_wdat;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  int checks = 0;
  int errors = 0;

  team_09_wb_master #(.TIMEOUT(8), .TW(16)) dut (
    .clk_i(clk_i), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_wdat(req_wdat), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O),
    .STB_O(STB_O), .CYC_O(CYC_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    step();
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (CYC_O !== 1'b0 || STB_O !== 1'b0 || WE_O !== 1'b0) begin errors++; $display("FAIL reset_bus_ctl: got cyc=%b stb=%b we=%b expected 0", CYC_O, STB_O, WE_O); end
    checks++; if (ADR_O !== 32'h0 || DAT_O !== 32'h0 || SEL_O !== 4'h0) begin errors++; $display("FAIL reset_bus_dat: got adr=%h dat=%h sel=%h expected 0", ADR_O, DAT_O, SEL_O); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp: got v=%b e=%b d=%h expected 0", rsp_valid, rsp_err, rsp_rdata); end
    nrst = 1'b1;
    step();
  endtask

  task automatic test_read_wait;
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0010; req_wdat = 32'h5555_AAAA; req_sel = 4'hF;
    ACK_I = 1'b0; DAT_I = 32'hBAD0_BAD0;
    step();
    req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (STB_O === 1'b1) n++;
      step();
    end
    if (STB_O === 1'b1) n++;
    checks++; if (WE_O !== 1'b0 || DAT_O !== 32'h0 || ADR_O !== 32'h3000_0010) begin errors++; $display("FAIL read_bus: got we=%b dat=%h adr=%h expected 0/00000000/30000010", WE_O, DAT_O, ADR_O); end
    ACK_I = 1'b1; DAT_I = 32'h1234_5678;
    step();
    ACK_I = 1'b0; DAT_I = 32'hBAD0_BAD0;
    checks++; if (n != 4) begin errors++; $display("FAIL read_stb_cycles: got %0d expected 4", n); end
    checks++; if (STB_O !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL read_rsp_timing: got stb=%b rsp_valid=%b expected 0/1", STB_O, rsp_valid); end
    checks++; if (rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin errors++; $display("FAIL read_rsp_data: got d=%h e=%b expected 12345678/0", rsp_rdata, rsp_err); end
    step();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL read_return_idle: got rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_timeout;
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0020; req_sel = 4'hF;
    ACK_I = 1'b0;
    step();
    req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && STB_O === 1'b1; i++) begin
      n++;
      step();
    end
    checks++; if (n != 8) begin errors++; $display("FAIL timeout_stb_cycles: got %0d expected 8", n); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rsp: got v=%b e=%b d=%h expected 1/1/00000000", rsp_valid, rsp_err, rsp_rdata); end
    step();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL timeout_after: got v=%b rdy=%b e=%b expected 0/1/1", rsp_valid, req_ready, rsp_err); end
  endtask

  task automatic test_ack_on_timeout;
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0030; req_sel = 4'hF;
    ACK_I = 1'b0;
    step();
    req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (STB_O === 1'b1) n++;
      step();
    end
    if (STB_O === 1'b1) n++;
    ACK_I = 1'b1; DAT_I = 32'hCAFE_F00D;
    step();
    ACK_I = 1'b0; DAT_I = 32'h0;
    checks++; if (n != 8) begin errors++; $display("FAIL ackto_stb_cycles: got %0d expected 8", n); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ackto_rsp: got v=%b e=%b d=%h expected 1/0/cafef00d", rsp_valid, rsp_err, rsp_rdata); end
    step();
  endtask

  task automatic test_write;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h3000_0004; req_wdat = 32'hDEAD_BEEF; req_sel = 4'hF;
    ACK_I = 1'b1;
    step();
    req_valid = 1'b0;
    checks++; if (CYC_O !== 1'b1 || STB_O !== 1'b1 || WE_O !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL write_ctl: got cyc=%b stb=%b we=%b rdy=%b expected 1/1/1/0", CYC_O, STB_O, WE_O, req_ready); end
    checks++; if (ADR_O !== 32'h3000_0004 || DAT_O !== 32'hDEAD_BEEF || SEL_O !== 4'hF) begin errors++; $display("FAIL write_bus: got adr=%h dat=%h sel=%h expected 30000004/deadbeef/f", ADR_O, DAT_O, SEL_O); end
    step();
    ACK_I = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL write_rsp: got v=%b e=%b d=%h expected 1/0/00000000", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (CYC_O !== 1'b0 || WE_O !== 1'b0 || ADR_O !== 32'h0 || DAT_O !== 32'h0) begin errors++; $display("FAIL write_bus_idle: got cyc=%b we=%b adr=%h dat=%h expected 0", CYC_O, WE_O, ADR_O, DAT_O); end
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL write_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_reset_busy;
    int pulses;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h3000_0040; req_wdat = 32'h1111_2222; req_sel = 4'h3;
    ACK_I = 1'b0;
    step();
    req_valid = 1'b0;
    checks++; if (CYC_O !== 1'b1) begin errors++; $display("FAIL rstbusy_pre: got cyc=%b expected 1", CYC_O); end
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    checks++; if (CYC_O !== 1'b0 || STB_O !== 1'b0 || ADR_O !== 32'h0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstbusy_post: got cyc=%b stb=%b adr=%h rdy=%b expected 0/0/0/1", CYC_O, STB_O, ADR_O, req_ready); end
    pulses = (rsp_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rsp_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstbusy_no_rsp: got %0d pulses expected 0", pulses); end
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0050; req_sel = 4'hF;
    ACK_I = 1'b1; DAT_I = 32'h0BAD_F00D;
    step();
    req_valid = 1'b0;
    step();
    ACK_I = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D || rsp_err !== 1'b0) begin errors++; $display("FAIL rstbusy_fresh: got v=%b d=%h e=%b expected 1/0badf00d/0", rsp_valid, rsp_rdata, rsp_err); end
    step();
  endtask

  task automatic test_back_to_back;
    logic [3:0] sel_tab [4];
    int acc_cyc [4];
    int k, n_rsp, cyc, sel_bad;
    logic was_ready;
    sel_tab[0] = 4'h1; sel_tab[1] = 4'h2; sel_tab[2] = 4'h4; sel_tab[3] = 4'h8;
    k = 0; n_rsp = 0; cyc = 0; sel_bad = 0;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h3000_0100; req_wdat = 32'hA5A5_0000; req_sel = sel_tab[0];
    ACK_I = 1'b1; DAT_I = 32'hFFFF_FFFF;
    for (int i = 0; i < 30 && n_rsp < 4; i++) begin
      was_ready = req_ready;
      step();
      cyc++;
      if (was_ready === 1'b1 && k < 4) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 4) begin
          req_sel = sel_tab[k]; req_adr = req_adr + 32'h4; req_wdat = req_wdat + 32'h1;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (STB_O === 1'b1 && (k == 0 || SEL_O !== sel_tab[k-1] || req_ready !== 1'b0)) sel_bad++;
      if (rsp_valid === 1'b1) begin
        n_rsp++;
        if (rsp_rdata !== 32'h0) sel_bad++;
      end
    end
    ACK_I = 1'b0;
    checks++; if (n_rsp != 4 || k != 4) begin errors++; $display("FAIL b2b_count: got rsp=%0d acc=%0d expected 4/4", n_rsp, k); end
    checks++; if (sel_bad != 0) begin errors++; $display("FAIL b2b_sel: got %0d bad cycles expected 0", sel_bad); end
    for (int j = 1; j < 4; j++) begin
      checks++; if (acc_cyc[j] - acc_cyc[j-1] != 3) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 3", j, acc_cyc[j] - acc_cyc[j-1]); end
    end
    step();
  endtask

  initial begin
    nrst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_wdat = '0; req_sel = '0;
    DAT_I = '0; ACK_I = 1'b0;
    test_reset();
    test_read_wait();
    test_timeout();
    test_ack_on_timeout();
    test_write();
    test_reset_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
